// File: rtl/i2c_frame_pkg.sv
// Shared constants and state encoding for the I2C command frame master and its slave
// counterpart.
package i2c_frame_pkg;

  localparam int unsigned FrameWords = 3;
  localparam logic [1:0]  LastWord   = 2'(FrameWords - 1);

  localparam logic [6:0]  SlaveAddrDefault = 7'b0101010;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StPulse    = 3'd2,
    StWaitBusy = 3'd3,
    StWaitDone = 3'd4,
    StGap      = 3'd5
  } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Down-counter that holds Count while load_i is high and flags the Count-th cycle after
// load_i drops.
module cycle_timer #(
  parameter int unsigned Count = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned Width = (Count < 2) ? 1 : $clog2(Count + 1);
  localparam logic [Width-1:0] Init = Width'(Count);
  localparam logic [Width-1:0] One  = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Init;
    end else if (cnt_q > One) begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= Init;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero count behaves like one so the owning state never stalls.
  assign done_o = (cnt_q <= One);

endmodule

// File: rtl/i2c_cmd_frame_sender.sv
// Serialises one command (opcode, arg0, arg1) into three write transactions on an I2C
// master controller.
module i2c_cmd_frame_sender
  import i2c_frame_pkg::*;
#(
  parameter logic [6:0]  SlaveAddr    = SlaveAddrDefault,
  parameter int unsigned EnCycles     = 10,
  parameter int unsigned GapCycles    = 20,
  parameter int unsigned StartTimeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_opcode_i,
  input  logic [31:0] cmd_arg0_i,
  input  logic [31:0] cmd_arg1_i,
  output logic        cmd_ready_o,
  input  logic        m_ready_i,
  output logic [6:0]  m_addr_o,
  output logic [31:0] m_data_in_o,
  output logic        m_enable_o,
  output logic        m_rw_o,
  output logic        frame_done_o,
  output logic        timeout_err_o,
  output logic [1:0]  word_cnt_o,
  output logic [7:0]  frames_sent_o,
  output logic [2:0]  state_out_o
);

  state_e                       state_q, state_d;
  logic [FrameWords-1:0][31:0]  words_q, words_d;
  logic [31:0]                  data_q, data_d;
  logic                         enable_q, enable_d;
  logic [1:0]                   word_cnt_q, word_cnt_d;
  logic [7:0]                   frames_q, frames_d;
  logic                         frame_done_q, frame_done_d;
  logic                         timeout_q, timeout_d;
  logic                         busy_seen_q, busy_seen_d;
  logic                         cmd_ready;
  logic                         en_done, gap_done, to_done;

  // Each timer holds its reload value outside its own state, so it restarts on every entry.
  cycle_timer #(.Count(EnCycles)) u_en_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q != StPulse),
    .done_o (en_done)
  );

  cycle_timer #(.Count(GapCycles)) u_gap_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q != StGap),
    .done_o (gap_done)
  );

  cycle_timer #(.Count(StartTimeout)) u_to_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (state_q != StWaitBusy),
    .done_o (to_done)
  );

  // The frame_done cycle already sits in IDLE but must not accept a command.
  assign cmd_ready = (state_q == StIdle) && !frame_done_q;

  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    data_d       = data_q;
    enable_d     = enable_q;
    word_cnt_d   = word_cnt_q;
    frames_d     = frames_q;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    busy_seen_d  = busy_seen_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready) begin
          words_d    = {cmd_arg1_i, cmd_arg0_i, cmd_opcode_i};
          data_d     = cmd_opcode_i;
          word_cnt_d = '0;
          timeout_d  = 1'b0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        enable_d    = 1'b1;
        busy_seen_d = 1'b0;
        state_d     = StPulse;
      end
      StPulse: begin
        if (!m_ready_i) begin
          busy_seen_d = 1'b1;
        end
        if (en_done) begin
          enable_d = 1'b0;
          state_d  = (busy_seen_q || !m_ready_i) ? StWaitDone : StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!m_ready_i) begin
          state_d = StWaitDone;
        end else if (to_done) begin
          timeout_d  = 1'b1;
          word_cnt_d = '0;
          state_d    = StIdle;
        end
      end
      StWaitDone: begin
        if (m_ready_i) begin
          if (word_cnt_q == LastWord) begin
            frame_done_d = 1'b1;
            frames_d     = frames_q + 8'd1;
            word_cnt_d   = '0;
            state_d      = StIdle;
          end else begin
            word_cnt_d = word_cnt_q + 2'd1;
            state_d    = StGap;
          end
        end
      end
      StGap: begin
        if (gap_done) begin
          data_d  = words_q[word_cnt_q];
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      words_q      <= '0;
      data_q       <= '0;
      enable_q     <= 1'b0;
      word_cnt_q   <= '0;
      frames_q     <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      data_q       <= data_d;
      enable_q     <= enable_d;
      word_cnt_q   <= word_cnt_d;
      frames_q     <= frames_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      busy_seen_q  <= busy_seen_d;
    end
  end

  assign cmd_ready_o   = cmd_ready;
  assign m_addr_o      = SlaveAddr;
  assign m_rw_o        = 1'b0;
  assign m_data_in_o   = data_q;
  assign m_enable_o    = enable_q;
  assign frame_done_o  = frame_done_q;
  assign timeout_err_o = timeout_q;
  assign word_cnt_o    = word_cnt_q;
  assign frames_sent_o = frames_q;
  assign state_out_o   = state_q;

endmodule
